// File: rtl/lightnew_pkg.sv
// Shared definitions for the lightnew plant: state encoding, watchdog limits
// and the bit positions of the controller command/condition vectors.
package lightnew_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_RUN   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_DONE  = 3'd4,
      ST_FAULT = 3'd5
   } state_e;

   localparam int Y_W = 14;
   localparam int X_W = 9;

   localparam logic [7:0] WDT_START_LIMIT = 8'd16;
   localparam logic [7:0] WDT_WAIT_LIMIT  = 8'd255;

   // y(n) lives at bit n-1 of y_in, x(n) at bit n-1 of x_out
   localparam int Y1_BIT = 0;
   localparam int Y2_BIT = 1;
   localparam int Y3_BIT = 2;
   localparam int Y4_BIT = 3;
   localparam int Y5_BIT = 4;
   localparam int Y6_BIT = 5;
   localparam int X2_BIT = 1;
   localparam int X3_BIT = 2;
   localparam int X9_BIT = 8;

   function automatic logic is_busy(input state_e s);
      return (s == ST_START) || (s == ST_RUN) || (s == ST_WAIT) || (s == ST_DONE);
   endfunction

endpackage

// File: rtl/lightnew_plant_if.sv
// Controller <-> plant signal bundle; the plant takes the slave side.
interface lightnew_plant_if;
   import lightnew_pkg::*;

   logic [Y_W-1:0] y_in;
   logic           start;
   logic           sense;
   logic [3:0]     cfg_delay;
   logic           clear;
   logic [X_W-1:0] x_out;
   logic           busy;
   logic           done;
   logic           fault;
   logic [7:0]     event_cnt;

   modport master (
      output y_in, start, sense, cfg_delay, clear,
      input  x_out, busy, done, fault, event_cnt
   );

   modport slave (
      input  y_in, start, sense, cfg_delay, clear,
      output x_out, busy, done, fault, event_cnt
   );

endinterface

// File: rtl/lightnew_wdt.sv
// Watchdog: 8-bit saturating cycle counter with clear/enable and a limit
// compare that fires during the limit-th enabled cycle.
module lightnew_wdt (
   input  logic       clk,
   input  logic       rst,
   input  logic       clear_i,
   input  logic       en_i,
   input  logic [7:0] limit_i,
   output logic       expired_o
);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = 8'd0;
      end else if (en_i && (cnt_q != 8'hFF)) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The count is zero in the first enabled cycle, so limit-1 marks the limit-th.
   assign expired_o = en_i && (cnt_q == (limit_i - 8'd1));

endmodule

// File: rtl/lightnew_plant.sv
// Plant-side sequencer: walks IDLE->START->RUN->WAIT->DONE under controller
// commands, with watchdog and illegal-command fault handling.
module lightnew_plant
   import lightnew_pkg::*;
(
   input logic            clk,
   input logic            rst,
   lightnew_plant_if.slave bus
);

   state_e         state_q, state_d;
   logic [3:0]     timer_q, timer_d;
   logic [X_W-1:0] x_out_q, x_out_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           fault_q, fault_d;
   logic [7:0]     ev_cnt_q, ev_cnt_d;

   logic ack, complete, illegal, strobe;
   logic wdt_en, wdt_clear, wdt_expired;
   logic [7:0] wdt_limit;

   assign ack      = bus.y_in[Y3_BIT] & bus.y_in[Y5_BIT] & bus.y_in[Y6_BIT];
   assign complete = bus.y_in[Y1_BIT] & bus.y_in[Y2_BIT] & bus.y_in[Y3_BIT];
   assign illegal  = bus.y_in[Y3_BIT] & bus.y_in[Y4_BIT];
   assign strobe   = bus.y_in[Y4_BIT];

   logic unused_y;
   assign unused_y = &{1'b0, bus.y_in[Y_W-1:Y6_BIT+1]};

   assign wdt_en    = (state_q == ST_START) || (state_q == ST_WAIT);
   assign wdt_limit = (state_q == ST_START) ? WDT_START_LIMIT : WDT_WAIT_LIMIT;
   assign wdt_clear = (state_d != state_q);

   lightnew_wdt u_wdt (
      .clk       (clk),
      .rst       (rst),
      .clear_i   (wdt_clear),
      .en_i      (wdt_en),
      .limit_i   (wdt_limit),
      .expired_o (wdt_expired)
   );

   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      ev_cnt_d = ev_cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               state_d  = ST_START;
               ev_cnt_d = 8'd0;
            end
         end
         ST_START: begin
            if (ack) begin
               state_d = ST_RUN;
               timer_d = bus.cfg_delay;
            end else if (wdt_expired) begin
               state_d = ST_FAULT;
            end
         end
         ST_RUN: begin
            if (timer_q == 4'd0) begin
               state_d = ST_WAIT;
            end else begin
               timer_d = timer_q - 4'd1;
            end
         end
         ST_WAIT: begin
            if (complete) begin
               state_d = ST_DONE;
            end else if (wdt_expired) begin
               state_d = ST_FAULT;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         ST_FAULT: begin
            if (bus.clear) begin
               state_d = ST_IDLE;
            end
         end
         default:  state_d = ST_IDLE;
      endcase

      // Strobes are counted in active states only; DONE holds the total.
      if (((state_q == ST_START) || (state_q == ST_RUN) || (state_q == ST_WAIT))
          && strobe && (ev_cnt_q != 8'hFF)) begin
         ev_cnt_d = ev_cnt_q + 8'd1;
      end

      if (illegal && is_busy(state_q)) begin
         state_d = ST_FAULT;
      end
   end

   // Outputs are registered from the next state so they line up with state_q.
   always_comb begin
      x_out_d = '0;
      unique case (state_d)
         ST_START: x_out_d[X9_BIT] = 1'b1;
         ST_RUN:   x_out_d[X2_BIT] = (timer_d == 4'd0);
         ST_WAIT:  x_out_d[X3_BIT] = bus.sense;
         ST_DONE:  x_out_d[X3_BIT] = 1'b1;
         default:  x_out_d = '0;
      endcase
      busy_d  = is_busy(state_d);
      done_d  = (state_d == ST_DONE);
      fault_d = (state_d == ST_FAULT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         timer_q  <= 4'd0;
         x_out_q  <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         fault_q  <= 1'b0;
         ev_cnt_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         x_out_q  <= x_out_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         fault_q  <= fault_d;
         ev_cnt_q <= ev_cnt_d;
      end
   end

   assign bus.x_out     = x_out_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.fault     = fault_q;
   assign bus.event_cnt = ev_cnt_q;

endmodule

// File: tb/tb_lightnew_plant.sv
// Directed bench for lightnew_plant: stimulus queues expected x2/done/fault
// events, an independent monitor pops and compares them as the DUT emits them.
module tb_lightnew_plant;
   import lightnew_pkg::*;

   localparam logic [13:0] Y1  = 14'h0001;
   localparam logic [13:0] Y2  = 14'h0002;
   localparam logic [13:0] Y3  = 14'h0004;
   localparam logic [13:0] Y4  = 14'h0008;
   localparam logic [13:0] ACK = 14'h0034;
   localparam logic [13:0] CMP = 14'h0007;

   typedef enum int {EV_X2, EV_DONE, EV_FAULT} ev_kind_e;
   typedef struct {
      ev_kind_e    kind;
      logic [8:0]  x;
      logic [7:0]  cnt;
      int          cyc;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc = 0;
   ev_t  exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   lightnew_plant_if bus();

   lightnew_plant dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_ev(input ev_kind_e k, input logic [8:0] x, input logic [7:0] c, input int at);
      ev_t e;
      e.kind = k;
      e.x    = x;
      e.cnt  = c;
      e.cyc  = at;
      exp_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: classify each DUT event at the falling edge and score it.
   initial begin
      logic     fault_prev;
      logic     hit;
      ev_kind_e k;
      ev_t      e;
      fault_prev = 1'b0;
      forever begin
         @(negedge clk);
         hit = 1'b1;
         k   = EV_X2;
         if (!rst)                           hit = 1'b0;
         else if (bus.done)                  k = EV_DONE;
         else if (bus.fault && !fault_prev)  k = EV_FAULT;
         else if (bus.x_out[1])              k = EV_X2;
         else                                hit = 1'b0;
         if (hit) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_event: got kind %0d, expected none (cycle %0d)", k, cyc);
            end else begin
               e = exp_q.pop_front();
               check("ev_kind",  32'(k),         32'(e.kind));
               check("ev_cycle", 32'(cyc),       32'(e.cyc));
               check("ev_x_out", bus.x_out,      e.x);
               check("ev_count", bus.event_cnt,  e.cnt);
            end
         end
         fault_prev = bus.fault;
      end
   end

   initial begin
      int  p;
      logic sp;
      bus.y_in = '0; bus.start = 0; bus.sense = 0; bus.cfg_delay = '0; bus.clear = 0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_x_out", bus.x_out, 0);
      check("rst_busy",  bus.busy, 0);
      check("rst_done",  bus.done, 0);
      check("rst_fault", bus.fault, 0);
      check("rst_cnt",   bus.event_cnt, 0);
      rst = 1'b1;
      tick();

      // Ack after 3 START cycles, dwell 5, then completion from WAIT
      p = cyc;
      bus.start = 1; bus.cfg_delay = 4'd5;
      tick();
      bus.start = 0;
      for (int i = 0; i < 3; i++) begin
         check("start_x9",   bus.x_out, 9'h100);
         check("start_busy", bus.busy, 1);
         if (i == 2) bus.y_in = ACK;
         tick();
      end
      bus.y_in = '0;
      expect_ev(EV_X2, 9'h002, 8'd0, p + 9);
      for (int i = 0; i < 6; i++) begin
         check("run_busy", bus.busy, 1);
         if (i < 5) check("run_x_quiet", bus.x_out, 0);
         tick();
      end
      check("wait_x3_low", bus.x_out, 0);
      bus.sense = 1;
      tick();
      check("wait_x3_high", bus.x_out, 9'h004);
      bus.sense = 0;
      tick();
      check("wait_x3_back", bus.x_out, 0);
      bus.y_in = CMP;
      expect_ev(EV_DONE, 9'h004, 8'd0, p + 13);
      tick();
      check("done_busy", bus.busy, 1);
      bus.y_in = '0;
      tick();
      check("idle_busy", bus.busy, 0);
      check("idle_done", bus.done, 0);
      check("idle_x",    bus.x_out, 0);

      // No acknowledge: START watchdog, then clear+start together
      p = cyc;
      bus.start = 1;
      tick();
      bus.start = 0;
      expect_ev(EV_FAULT, 9'h000, 8'd0, p + 17);
      for (int i = 0; i < 16; i++) begin
         check("wdt_start_x9", bus.x_out, 9'h100);
         tick();
      end
      check("wdt_fault", bus.fault, 1);
      check("wdt_busy",  bus.busy, 0);
      bus.start = 1;
      tick();
      check("fault_ignores_start", bus.fault, 1);
      bus.clear = 1;
      tick();
      bus.clear = 0; bus.start = 0;
      check("clear_fault", bus.fault, 0);
      check("clear_idle",  bus.busy, 0);
      tick();
      check("start_ignored_on_clear", bus.busy, 0);
      check("start_ignored_x",        bus.x_out, 0);

      // Strobe saturation and WAIT watchdog with sense toggling
      p = cyc;
      bus.start = 1; bus.cfg_delay = 4'd15;
      tick();
      bus.start = 0; bus.y_in = Y4;
      tick();
      tick();
      bus.y_in = ACK;
      tick();
      bus.y_in = Y4;
      check("sat_cnt_start", bus.event_cnt, 2);
      expect_ev(EV_X2, 9'h002, 8'd17, p + 19);
      repeat (16) tick();
      check("sat_cnt_run", bus.event_cnt, 18);
      expect_ev(EV_FAULT, 9'h000, 8'd255, p + 275);
      sp = 1'b0;
      for (int i = 0; i < 255; i++) begin
         check("x3_follows_sense", bus.x_out, sp ? 9'h004 : 9'h000);
         if (i == 236) check("cnt_before_sat", bus.event_cnt, 254);
         if (i == 254) check("cnt_saturated",  bus.event_cnt, 255);
         bus.sense = ((i % 3) != 0);
         sp = bus.sense;
         tick();
      end
      bus.sense = 0;
      check("wdt_wait_fault", bus.fault, 1);
      repeat (25) tick();
      check("cnt_hold_fault", bus.event_cnt, 255);
      bus.y_in = '0; bus.clear = 1;
      tick();
      bus.clear = 0;
      check("clear_after_wait", bus.fault, 0);

      // Illegal y3&y4 in RUN
      p = cyc;
      bus.start = 1; bus.cfg_delay = 4'd10;
      tick();
      bus.start = 0; bus.y_in = ACK;
      tick();
      check("cnt_cleared_on_start", bus.event_cnt, 0);
      bus.y_in = Y3 | Y4;
      expect_ev(EV_FAULT, 9'h000, 8'd1, p + 3);
      tick();
      check("illegal_fault", bus.fault, 1);
      bus.y_in = '0; bus.clear = 1;
      tick();
      bus.clear = 0;

      // Reset mid-RUN, then a zero-dwell cycle
      bus.start = 1; bus.cfg_delay = 4'd8;
      tick();
      bus.start = 0; bus.y_in = ACK;
      tick();
      bus.y_in = Y4;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("mid_rst_x",     bus.x_out, 0);
      check("mid_rst_busy",  bus.busy, 0);
      check("mid_rst_done",  bus.done, 0);
      check("mid_rst_fault", bus.fault, 0);
      check("mid_rst_cnt",   bus.event_cnt, 0);
      bus.y_in = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      tick();
      p = cyc;
      bus.start = 1; bus.cfg_delay = 4'd0;
      tick();
      bus.start = 0; bus.y_in = ACK;
      expect_ev(EV_X2, 9'h002, 8'd0, p + 2);
      tick();
      bus.y_in = '0;
      tick();
      bus.y_in = Y1 | Y2 | Y3;
      expect_ev(EV_DONE, 9'h004, 8'd0, p + 4);
      tick();
      bus.y_in = '0;
      tick();
      check("post_rst_idle", bus.busy, 0);

      repeat (3) tick();
      check("pending_events", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lightnew_plant.md
LIGHTNEW_PLANT -- requirements
Module: lightnew_plant

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Port: clk  input  1  clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous active-low reset.
REQ-004 Port: y_in  input  14  controller command vector; bit i carries controller output y(i+1).
REQ-005 Port: start  input  1  one-cycle request to begin a plant cycle.
REQ-006 Port: sense  input  1  external sensor level, forwarded as x3 in WAIT.
REQ-007 Port: cfg_delay  input  4  RUN dwell in cycles, sampled on START->RUN.
REQ-008 Port: clear  input  1  synchronous fault clear.
REQ-009 Port: x_out  output  9  condition vector to controller; bit i drives controller input x(i+1).
REQ-010 Port: busy  output  1  high in every state except IDLE and FAULT.
REQ-011 Port: done  output  1  one-cycle pulse on plant-cycle completion.
REQ-012 Port: fault  output  1  high in FAULT.
REQ-013 Port: event_cnt  output  8  count of y4 strobes in the current cycle, saturating.

Function
REQ-014 States SHALL be IDLE, START, RUN, WAIT, DONE, FAULT; all outputs are registered.
REQ-015 IDLE: x_out=0; on start=1 go to START; otherwise stay.
REQ-016 START: x9=1, other x bits 0; when y3&y5&y6=1, go to RUN and load dwell timer with cfg_delay.
REQ-017 RUN: timer decrements each cycle; x_out=0 while timer nonzero; when timer is 0, drive x2=1 for exactly one cycle and go to WAIT. cfg_delay=0 gives x2 on the first RUN cycle.
REQ-018 WAIT: x3=sense and other x bits 0; when y1&y2&y3=1, go to DONE.
REQ-019 DONE: x3=1 and done=1 for one cycle, then go to IDLE.
REQ-020 FAULT: x_out=0 and fault=1; leave only on clear=1, going to IDLE.
REQ-021 Watchdog: count the cycles spent in START or WAIT. Entering FAULT SHALL occur on the 16th START cycle without acknowledge, or on the 255th WAIT cycle without completion. The count resets on every state change.
REQ-022 Illegal command: y3&y4=1 in any state other than IDLE or FAULT SHALL force FAULT on the next edge. This check takes priority over all other transitions.
REQ-023 event_cnt SHALL clear on IDLE->START, increment in each busy cycle with y4=1, and saturate at 255; it holds its value in DONE, IDLE and FAULT.
REQ-024 start SHALL be ignored outside IDLE; clear SHALL be ignored outside FAULT.
REQ-025 clear and start in the same cycle in FAULT: clear SHALL be taken; start SHALL be ignored.
REQ-026 Unused x bits (x4–x8) SHALL be constant 0.

Reset
REQ-027 Asserting rst SHALL immediately force: state=IDLE, x_out=0, busy=0, done=0, fault=0, event_cnt=0, timers=0.
REQ-028 Reset mid-cycle (any state) SHALL abandon the cycle with no done pulse. Release is synchronous to the next rising edge.

Structure
REQ-029 The shared package lightnew_pkg SHALL hold:
- state encoding;
- WDT_START_LIMIT=16 and WDT_WAIT_LIMIT=255;
- y and x bit-index constants.
REQ-030 The watchdog SHALL be one sub-module, lightnew_wdt: 8-bit counter with clear, enable and limit compare.

Verification
REQ-031 Directed scenarios:
- rst low mid-RUN → all outputs 0 and IDLE immediately; after release, start works normally.
- start, then y3/y5/y6=1 after 3 cycles, cfg_delay=5 → x9 high 3 cycles; x2 pulse 6 cycles after ack; busy high throughout.
- start, then no acknowledge → fault=1 after 16 cycles in START; clear → IDLE; a start in that same cycle is ignored.
- In WAIT: sense toggling, 300 y4 strobes, no completion → x3 follows sense; event_cnt stops at 255; FAULT on the 255th WAIT cycle.
- In WAIT: y1/y2/y3=1 → one-cycle done with x3=1, then IDLE.
- In RUN: y3 and y4 high together → FAULT on the next edge.
